// File: rtl/uart_framed.sv
// Full-duplex framed UART: oversampled 3-sample majority receiver with a one-entry holding
// register and per-frame error pulses, plus a transmitter that can run frames back-to-back.
module uart_framed #(
    parameter int unsigned CLOCKFRQ     = 48_000_000,
    parameter int unsigned BAUDRATE     = 3_000_000,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned LED_STRETCH  = 17,
    parameter int unsigned CLOCK_DIVIDE = CLOCKFRQ / (BAUDRATE * OVERSAMPLE) - 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic                 o_tx,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_break_det,
    output logic                 o_is_receiving,
    output logic                 o_is_transmitting
);

    localparam int unsigned DIV_W      = (CLOCK_DIVIDE > 0) ? $clog2(CLOCK_DIVIDE + 1) : 1;
    localparam int unsigned TCNT_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W     = $clog2(DATA_BITS);
    localparam int unsigned HAS_PAR    = (PARITY != 0) ? 1 : 0;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + HAS_PAR + STOP_BITS;
    localparam int unsigned FB_W       = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(CLOCK_DIVIDE);
    localparam logic [TCNT_W-1:0] T_S0       = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] T_S1       = TCNT_W'(OVERSAMPLE / 2);
    localparam logic [TCNT_W-1:0] T_S2       = TCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TCNT_W-1:0] T_PRE      = TCNT_W'(OVERSAMPLE - 2);
    localparam logic [TCNT_W-1:0] T_LAST     = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] B_LAST     = BCNT_W'(DATA_BITS - 1);
    localparam logic [FB_W-1:0]   F_LAST     = FB_W'(FRAME_BITS - 1);

    // ------------------------------------------------------------------ receiver
    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxBreakWait
    } rx_state_e;

    rx_state_e               r_rx_state, w_rx_state_d;
    logic                    r_rx_meta, r_rx_sync;
    logic [DIV_W-1:0]        r_rx_div, w_rx_div_d;
    logic [TCNT_W-1:0]       r_rx_tcnt, w_rx_tcnt_d;
    logic [BCNT_W-1:0]       r_rx_bcnt, w_rx_bcnt_d;
    logic [1:0]              r_rx_smp, w_rx_smp_d;
    logic [DATA_BITS-1:0]    r_rx_shift, w_rx_shift_d;
    logic                    r_rx_par_bit, w_rx_par_bit_d;
    logic                    r_rx_par_bad, w_rx_par_bad_d;
    logic                    r_rx_valid, w_rx_valid_d;
    logic [DATA_BITS-1:0]    r_rx_data, w_rx_data_d;
    logic                    r_frame_err, w_frame_err_d;
    logic                    r_parity_err, w_parity_err_d;
    logic                    r_overrun, w_overrun_d;
    logic                    r_break_det, w_break_det_d;
    logic [LED_STRETCH-1:0]  r_rx_led, w_rx_led_d;

    logic w_rx_tick, w_rx_bit_end, w_rx_decide, w_rx_maj, w_rx_par_exp;

    assign w_rx_tick    = (r_rx_div == '0);
    assign w_rx_bit_end = w_rx_tick && (r_rx_tcnt == T_LAST);
    assign w_rx_decide  = w_rx_tick && (r_rx_tcnt == T_S2);
    // Third sample is taken live at the decision tick.
    assign w_rx_maj     = (r_rx_smp[0] & r_rx_smp[1]) | (r_rx_smp[0] & r_rx_sync) |
                          (r_rx_smp[1] & r_rx_sync);
    assign w_rx_par_exp = (PARITY == 2) ? ^r_rx_shift : ~^r_rx_shift;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_state   <= RxIdle;
            r_rx_div     <= DIV_RELOAD;
            r_rx_tcnt    <= '0;
            r_rx_bcnt    <= '0;
            r_rx_smp     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
            r_rx_par_bad <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_break_det  <= 1'b0;
            r_rx_led     <= '0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_state   <= w_rx_state_d;
            r_rx_div     <= w_rx_div_d;
            r_rx_tcnt    <= w_rx_tcnt_d;
            r_rx_bcnt    <= w_rx_bcnt_d;
            r_rx_smp     <= w_rx_smp_d;
            r_rx_shift   <= w_rx_shift_d;
            r_rx_par_bit <= w_rx_par_bit_d;
            r_rx_par_bad <= w_rx_par_bad_d;
            r_rx_valid   <= w_rx_valid_d;
            r_rx_data    <= w_rx_data_d;
            r_frame_err  <= w_frame_err_d;
            r_parity_err <= w_parity_err_d;
            r_overrun    <= w_overrun_d;
            r_break_det  <= w_break_det_d;
            r_rx_led     <= w_rx_led_d;
        end
    end

    always_comb begin
        w_rx_state_d   = r_rx_state;
        w_rx_div_d     = w_rx_tick ? DIV_RELOAD : r_rx_div - 1'b1;
        w_rx_tcnt_d    = r_rx_tcnt;
        w_rx_bcnt_d    = r_rx_bcnt;
        w_rx_smp_d     = r_rx_smp;
        w_rx_shift_d   = r_rx_shift;
        w_rx_par_bit_d = r_rx_par_bit;
        w_rx_par_bad_d = r_rx_par_bad;
        w_rx_valid_d   = r_rx_valid & ~i_rx_ready;
        w_rx_data_d    = r_rx_data;
        w_frame_err_d  = 1'b0;
        w_parity_err_d = 1'b0;
        w_overrun_d    = 1'b0;
        w_break_det_d  = 1'b0;
        w_rx_led_d     = (r_rx_led != '0) ? r_rx_led - 1'b1 : r_rx_led;

        if (r_rx_state != RxIdle && w_rx_tick) begin
            w_rx_tcnt_d = w_rx_bit_end ? '0 : r_rx_tcnt + 1'b1;
            if (r_rx_tcnt == T_S0) w_rx_smp_d[0] = r_rx_sync;
            if (r_rx_tcnt == T_S1) w_rx_smp_d[1] = r_rx_sync;
        end

        case (r_rx_state)
            RxIdle: begin
                if (!r_rx_sync) begin
                    w_rx_state_d   = RxStart;
                    w_rx_div_d     = DIV_RELOAD;
                    w_rx_tcnt_d    = '0;
                    w_rx_bcnt_d    = '0;
                    w_rx_par_bit_d = 1'b0;
                    w_rx_par_bad_d = 1'b0;
                end
            end
            RxStart: begin
                if (w_rx_decide && w_rx_maj) begin
                    w_rx_state_d = RxIdle;
                end else if (w_rx_bit_end) begin
                    w_rx_state_d = RxData;
                    w_rx_led_d   = '1;
                end
            end
            RxData: begin
                if (w_rx_decide) w_rx_shift_d = {w_rx_maj, r_rx_shift[DATA_BITS-1:1]};
                if (w_rx_bit_end) begin
                    if (r_rx_bcnt == B_LAST) begin
                        w_rx_state_d = (PARITY != 0) ? RxParity : RxStop;
                    end else begin
                        w_rx_bcnt_d = r_rx_bcnt + 1'b1;
                    end
                end
            end
            RxParity: begin
                if (w_rx_decide) begin
                    w_rx_par_bit_d = w_rx_maj;
                    w_rx_par_bad_d = (w_rx_maj != w_rx_par_exp);
                end
                if (w_rx_bit_end) w_rx_state_d = RxStop;
            end
            RxStop: begin
                // Decide mid-bit so a back-to-back start edge is not missed.
                if (w_rx_decide) begin
                    if (w_rx_maj) begin
                        w_rx_state_d = RxIdle;
                        if (r_rx_par_bad) begin
                            w_parity_err_d = 1'b1;
                        end else if (!r_rx_valid || i_rx_ready) begin
                            w_rx_data_d  = r_rx_shift;
                            w_rx_valid_d = 1'b1;
                        end else begin
                            w_overrun_d = 1'b1;
                        end
                    end else begin
                        w_rx_state_d  = RxBreakWait;
                        w_frame_err_d = 1'b1;
                        w_break_det_d = (r_rx_shift == '0) && !r_rx_par_bit;
                    end
                end
            end
            RxBreakWait: begin
                if (r_rx_sync) w_rx_state_d = RxIdle;
            end
            default: w_rx_state_d = RxIdle;
        endcase
    end

    assign o_rx_valid     = r_rx_valid;
    assign o_rx_data      = r_rx_data;
    assign o_frame_err    = r_frame_err;
    assign o_parity_err   = r_parity_err;
    assign o_overrun      = r_overrun;
    assign o_break_det    = r_break_det;
    assign o_is_receiving = (r_rx_led != '0);

    // --------------------------------------------------------------- transmitter
    typedef enum logic {TxIdle, TxSend} tx_state_e;

    tx_state_e               r_tx_state, w_tx_state_d;
    logic [DIV_W-1:0]        r_tx_div, w_tx_div_d;
    logic [TCNT_W-1:0]       r_tx_tcnt, w_tx_tcnt_d;
    logic [FB_W-1:0]         r_tx_bcnt, w_tx_bcnt_d;
    logic [FRAME_BITS-1:0]   r_tx_shift, w_tx_shift_d;
    logic [LED_STRETCH-1:0]  r_tx_led, w_tx_led_d;
    logic [FRAME_BITS-1:0]   w_tx_frame;
    logic                    w_tx_tick, w_tx_pre_final;

    assign w_tx_tick = (r_tx_div == '0);
    // The last clock of the final stop bit is spent in idle (line high, ready high), so an
    // accept there starts the next frame with no gap and the frame keeps its exact length.
    assign w_tx_pre_final = (r_tx_bcnt == F_LAST) &&
                            ((CLOCK_DIVIDE == 0) ? (w_tx_tick && r_tx_tcnt == T_PRE)
                                                 : (r_tx_tcnt == T_LAST &&
                                                    r_tx_div == DIV_W'(1)));

    always_comb begin
        w_tx_frame                  = '1;
        w_tx_frame[0]               = 1'b0;
        w_tx_frame[DATA_BITS:1]     = i_tx_data;
        if (PARITY != 0) begin
            w_tx_frame[DATA_BITS+1] = (PARITY == 2) ? ^i_tx_data : ~^i_tx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= TxIdle;
            r_tx_div   <= DIV_RELOAD;
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
            r_tx_shift <= '1;
            r_tx_led   <= '0;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_div   <= w_tx_div_d;
            r_tx_tcnt  <= w_tx_tcnt_d;
            r_tx_bcnt  <= w_tx_bcnt_d;
            r_tx_shift <= w_tx_shift_d;
            r_tx_led   <= w_tx_led_d;
        end
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_div_d   = w_tx_tick ? DIV_RELOAD : r_tx_div - 1'b1;
        w_tx_tcnt_d  = r_tx_tcnt;
        w_tx_bcnt_d  = r_tx_bcnt;
        w_tx_shift_d = r_tx_shift;
        w_tx_led_d   = (r_tx_led != '0) ? r_tx_led - 1'b1 : r_tx_led;

        case (r_tx_state)
            TxIdle: begin
                if (i_tx_valid) begin
                    w_tx_state_d = TxSend;
                    w_tx_shift_d = w_tx_frame;
                    w_tx_bcnt_d  = '0;
                    w_tx_tcnt_d  = '0;
                    w_tx_div_d   = DIV_RELOAD;
                    w_tx_led_d   = '1;
                end
            end
            TxSend: begin
                if (w_tx_pre_final) begin
                    w_tx_state_d = TxIdle;
                end else if (w_tx_tick) begin
                    if (r_tx_tcnt == T_LAST) begin
                        w_tx_tcnt_d  = '0;
                        w_tx_bcnt_d  = r_tx_bcnt + 1'b1;
                        w_tx_shift_d = {1'b1, r_tx_shift[FRAME_BITS-1:1]};
                    end else begin
                        w_tx_tcnt_d = r_tx_tcnt + 1'b1;
                    end
                end
            end
            default: w_tx_state_d = TxIdle;
        endcase
    end

    assign o_tx              = (r_tx_state == TxSend) ? r_tx_shift[0] : 1'b1;
    assign o_tx_ready        = (r_tx_state == TxIdle);
    assign o_is_transmitting = (r_tx_led != '0);

endmodule

// File: tb/tb_uart_framed.sv
// Bench for uart_framed: 8N1 loopback/receive instance, 8E1 receive instance, 7N2 transmit
// instance; received words are checked against a scoreboard queue filled at stimulus time.
module tb_uart_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic rst_a, rst_b;

    // 8N1 instance: loopback or bench-driven rx
    logic       rx_drv_a, loop_a, rx_a, tx_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       fe_a, pe_a, ov_a, bk_a, recv_a, xmit_a;
    assign rx_a = loop_a ? tx_a : rx_drv_a;

    // 8E1 instance: receive only
    logic       rx_drv_p, tx_p, tx_valid_p, tx_ready_p, rx_valid_p, rx_ready_p;
    logic [7:0] tx_data_p, rx_data_p;
    logic       fe_p, pe_p, ov_p, bk_p, recv_p, xmit_p;

    // 7N2 instance: transmit only
    logic       rx_b, tx_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
    logic [6:0] tx_data_b, rx_data_b;
    logic       fe_b, pe_b, ov_b, bk_b, recv_b, xmit_b;

    uart_framed u_a (
        .i_clk(clk), .i_rst(rst_a), .i_rx(rx_a), .o_tx(tx_a),
        .i_tx_valid(tx_valid_a), .i_tx_data(tx_data_a), .o_tx_ready(tx_ready_a),
        .o_rx_valid(rx_valid_a), .o_rx_data(rx_data_a), .i_rx_ready(rx_ready_a),
        .o_frame_err(fe_a), .o_parity_err(pe_a), .o_overrun(ov_a), .o_break_det(bk_a),
        .o_is_receiving(recv_a), .o_is_transmitting(xmit_a)
    );

    uart_framed #(.PARITY(2)) u_p (
        .i_clk(clk), .i_rst(rst_a), .i_rx(rx_drv_p), .o_tx(tx_p),
        .i_tx_valid(tx_valid_p), .i_tx_data(tx_data_p), .o_tx_ready(tx_ready_p),
        .o_rx_valid(rx_valid_p), .o_rx_data(rx_data_p), .i_rx_ready(rx_ready_p),
        .o_frame_err(fe_p), .o_parity_err(pe_p), .o_overrun(ov_p), .o_break_det(bk_p),
        .o_is_receiving(recv_p), .o_is_transmitting(xmit_p)
    );

    uart_framed #(.DATA_BITS(7), .STOP_BITS(2)) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_rx(rx_b), .o_tx(tx_b),
        .i_tx_valid(tx_valid_b), .i_tx_data(tx_data_b), .o_tx_ready(tx_ready_b),
        .o_rx_valid(rx_valid_b), .o_rx_data(rx_data_b), .i_rx_ready(rx_ready_b),
        .o_frame_err(fe_b), .o_parity_err(pe_b), .o_overrun(ov_b), .o_break_det(bk_b),
        .o_is_receiving(recv_b), .o_is_transmitting(xmit_b)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboards and pulse counters
    logic [7:0] q_a[$];
    logic [7:0] q_p[$];
    int fe_a_cnt = 0, pe_a_cnt = 0, ov_a_cnt = 0, bk_a_cnt = 0;
    int fe_p_cnt = 0, pe_p_cnt = 0, ov_p_cnt = 0, bk_p_cnt = 0;

    always @(negedge clk) begin
        if (fe_a === 1'b1) fe_a_cnt++;
        if (pe_a === 1'b1) pe_a_cnt++;
        if (ov_a === 1'b1) ov_a_cnt++;
        if (bk_a === 1'b1) bk_a_cnt++;
        if (fe_p === 1'b1) fe_p_cnt++;
        if (pe_p === 1'b1) pe_p_cnt++;
        if (ov_p === 1'b1) ov_p_cnt++;
        if (bk_p === 1'b1) bk_p_cnt++;
        if (rx_valid_a === 1'b1 && rx_ready_a === 1'b1) begin
            check("rx_a frame expected", (q_a.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (q_a.size() > 0) check("rx_a data", {24'd0, rx_data_a}, {24'd0, q_a.pop_front()});
        end
        if (rx_valid_p === 1'b1 && rx_ready_p === 1'b1) begin
            check("rx_p frame expected", (q_p.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (q_p.size() > 0) check("rx_p data", {24'd0, rx_data_p}, {24'd0, q_p.pop_front()});
        end
    end

    function automatic logic [15:0] frame8(input logic [7:0] d, input bit has_par,
                                           input logic pbit);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (has_par) f[9] = pbit;
        return f;
    endfunction

    function automatic logic [15:0] frame7(input logic [6:0] d);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[7:1] = d;
        return f;
    endfunction

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_drv_a = v;
        else            rx_drv_p = v;
    endtask

    // 16 clocks per bit; optional one-clock corruption mid data bit; optional
    // one-cycle rx_ready_a pulse at a given clock offset into the frame.
    task automatic drive_frame(input int which, input logic [15:0] bits, input int nbits,
                               input bit corrupt, input int ready_at);
        logic v;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                v = bits[b];
                if (corrupt && b >= 1 && b <= 8 && k == 8) v = ~v;
                set_rx(which, v);
                if (ready_at >= 0 && b * 16 + k == ready_at)     rx_ready_a = 1'b1;
                if (ready_at >= 0 && b * 16 + k == ready_at + 1) rx_ready_a = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input int which, input int max_cycles);
        int i;
        i = 0;
        while (i < max_cycles && ((which == 0) ? q_a.size() : q_p.size()) != 0) begin
            @(negedge clk);
            i++;
        end
        check((which == 0) ? "rx_a drain" : "rx_p drain",
              (which == 0) ? q_a.size() : q_p.size(), 0);
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       pbit;
        logic       exp_perr;
    } pvec_t;

    pvec_t       pv[6];
    logic [15:0] fb, fb2;
    int          fe0, bk0, pe0, ov0;

    initial begin
        pv[0] = '{8'h03, 1'b1, 1'b1};
        pv[1] = '{8'h03, 1'b0, 1'b0};
        pv[2] = '{8'h01, 1'b1, 1'b0};
        pv[3] = '{8'h01, 1'b0, 1'b1};
        pv[4] = '{8'hFF, 1'b0, 1'b0};
        pv[5] = '{8'h80, 1'b0, 1'b1};

        rst_a = 1'b1; rst_b = 1'b1;
        rx_drv_a = 1'b1; loop_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0; rx_ready_a = 1'b0;
        rx_drv_p = 1'b1; tx_valid_p = 1'b0; tx_data_p = '0; rx_ready_p = 1'b1;
        rx_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = '0; rx_ready_b = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        check("reset tx", tx_a, 1);
        check("reset tx_ready", tx_ready_a, 1);
        check("reset rx_valid", rx_valid_a, 0);
        check("reset rx_data", rx_data_a, 0);
        check("reset is_receiving", recv_a, 0);
        check("reset is_transmitting", xmit_a, 0);
        check("reset tx_b", tx_b, 1);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (5) @(negedge clk);

        // 1: 8N1 loopback of 0xA5
        loop_a = 1'b1; rx_ready_a = 1'b1;
        fb = frame8(8'hA5, 1'b0, 1'b0);
        q_a.push_back(8'hA5);
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        for (int j = 0; j < 160; j++) begin
            if (j % 16 == 8) check("t1 tx bit", tx_a, fb[j / 16]);
            if (j == 1)   check("t1 tx_ready low early", tx_ready_a, 0);
            if (j == 158) check("t1 tx_ready low late", tx_ready_a, 0);
            if (j == 159) check("t1 tx_ready back", tx_ready_a, 1);
            if (j == 20)  check("t1 is_transmitting", xmit_a, 1);
            @(negedge clk);
        end
        wait_drain(0, 400);
        check("t1 is_receiving", recv_a, 1);
        check("t1 no errors", fe_a_cnt + pe_a_cnt + ov_a_cnt + bk_a_cnt, 0);
        loop_a = 1'b0;
        repeat (5) @(negedge clk);

        // 3a: overrun with rx_ready held low
        rx_ready_a = 1'b0;
        q_a.push_back(8'h11);
        drive_frame(0, frame8(8'h11, 1'b0, 1'b0), 10, 1'b0, -1);
        drive_frame(0, frame8(8'h22, 1'b0, 1'b0), 10, 1'b0, -1);
        repeat (20) @(negedge clk);
        check("t3 overrun pulses", ov_a_cnt, 1);
        check("t3 rx_data kept", rx_data_a, 8'h11);
        check("t3 rx_valid held", rx_valid_a, 1);
        rx_ready_a = 1'b1;
        wait_drain(0, 50);
        repeat (3) @(negedge clk);

        // 3b: rx_ready pulsed exactly at the second frame's stop decision
        rx_ready_a = 1'b0;
        q_a.push_back(8'h11);
        drive_frame(0, frame8(8'h11, 1'b0, 1'b0), 10, 1'b0, -1);
        q_a.push_back(8'h22);
        drive_frame(0, frame8(8'h22, 1'b0, 1'b0), 10, 1'b0, 156);
        repeat (20) @(negedge clk);
        check("t3b no new overrun", ov_a_cnt, 1);
        check("t3b rx_data new", rx_data_a, 8'h22);
        check("t3b rx_valid", rx_valid_a, 1);
        rx_ready_a = 1'b1;
        wait_drain(0, 50);
        repeat (3) @(negedge clk);

        // 4: 30-bit break, then a normal frame
        fe0 = fe_a_cnt; bk0 = bk_a_cnt;
        @(negedge clk) rx_drv_a = 1'b0;
        repeat (30 * 16) @(negedge clk);
        check("t4 frame_err once", fe_a_cnt - fe0, 1);
        check("t4 break_det once", bk_a_cnt - bk0, 1);
        rx_drv_a = 1'b1;
        repeat (32) @(negedge clk);
        q_a.push_back(8'h5A);
        drive_frame(0, frame8(8'h5A, 1'b0, 1'b0), 10, 1'b0, -1);
        wait_drain(0, 50);
        check("t4 frame_err still once", fe_a_cnt - fe0, 1);
        check("t4 break_det still once", bk_a_cnt - bk0, 1);

        // 5: idle glitch, then majority outvotes one bad clock per data bit
        fe0 = fe_a_cnt; pe0 = pe_a_cnt; ov0 = ov_a_cnt; bk0 = bk_a_cnt;
        @(negedge clk) rx_drv_a = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv_a = 1'b1;
        repeat (320) @(negedge clk);
        check("t5 glitch no rx_valid", rx_valid_a, 0);
        check("t5 glitch no errors",
              (fe_a_cnt - fe0) + (pe_a_cnt - pe0) + (ov_a_cnt - ov0) + (bk_a_cnt - bk0), 0);
        q_a.push_back(8'hC3);
        drive_frame(0, frame8(8'hC3, 1'b0, 1'b0), 10, 1'b1, -1);
        wait_drain(0, 50);
        check("t5 corrupted frame no errors", fe_a_cnt - fe0, 0);

        // 2: even parity table on the 8E1 instance
        for (int i = 0; i < 6; i++) begin
            pe0 = pe_p_cnt;
            if (!pv[i].exp_perr) q_p.push_back(pv[i].data);
            drive_frame(1, frame8(pv[i].data, 1'b1, pv[i].pbit), 11, 1'b0, -1);
            repeat (20) @(negedge clk);
            check("t2 parity_err pulses", pe_p_cnt - pe0, {31'd0, pv[i].exp_perr});
            check("t2 rx_valid after", rx_valid_p, 0);
            wait_drain(1, 50);
        end
        check("t2 no frame_err", fe_p_cnt, 0);
        check("t2 no overrun", ov_p_cnt, 0);

        // 6: 7N2 back-to-back frames, then reset mid-frame
        fb  = frame7(7'h41);
        fb2 = frame7(7'h7F);
        tx_data_b = 7'h41; tx_valid_b = 1'b1;
        @(negedge clk);
        tx_data_b = 7'h7F;
        for (int j = 0; j < 222; j++) begin
            if (j < 160 && j % 16 == 8) check("t6 frame1 bit", tx_b, fb[j / 16]);
            if (j >= 160 && j % 16 == 8) check("t6 frame2 bit", tx_b, fb2[(j - 160) / 16]);
            if (j == 158) check("t6 tx_ready low", tx_ready_b, 0);
            if (j == 159) begin
                check("t6 tx_ready at frame end", tx_ready_b, 1);
                check("t6 stop level", tx_b, 1);
            end
            if (j == 160) begin
                check("t6 no gap start", tx_b, 0);
                tx_valid_b = 1'b0;
            end
            if (j == 220) rst_b = 1'b1;
            if (j == 221) begin
                rst_b = 1'b0;
                check("t6 tx after reset", tx_b, 1);
                check("t6 tx_ready after reset", tx_ready_b, 1);
            end
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("t6 tx idle later", tx_b, 1);
        check("t6 tx_ready idle later", tx_ready_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
